// File: rtl/fft_reorder_256.sv
// Purpose: reorders one bit-reversed FFT output frame into natural bin order using ping-pong banks.
// Latency: natural bin k leaves registered one edge after frame completion plus k (edge T+1+k).
// Backpressure: none; input may gap with In_valid=0, output streams N contiguous cycles per frame.
module fft_reorder_256 #(
  parameter int N = 256,
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         In_valid,
  input  logic         In_sync,
  input  logic [W-1:0] Data_in_r,
  input  logic [W-1:0] Data_in_i,
  output logic         Out_valid,
  output logic         Out_sync,
  output logic [W-1:0] Data_out_r,
  output logic [W-1:0] Data_out_i,
  output logic         Sync_err
);

  localparam int AW = $clog2(N);

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_RUN}  rstate_t;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
    return r;
  endfunction

  // Both banks live in one array; the top address bit selects the bank.
  logic [2*W-1:0] mem_q [0:2*N-1];

  wstate_t       wstate_q, wstate_d;
  logic [AW-1:0] j_q, j_d;
  logic          wbank_q, wbank_d;
  logic          serr_q, serr_d;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          frame_done;

  rstate_t       rstate_q, rstate_d;
  logic [AW-1:0] k_q, k_d;
  logic          rbank_q, rbank_d;
  logic          ovld_q, ovld_d;
  logic          osync_q, osync_d;
  logic [W-1:0]  or_q, or_d;
  logic [W-1:0]  oi_q, oi_d;

  // Write side: track input index, pick the bit-reversed address, detect restart and completion.
  always_comb begin
    wstate_d   = wstate_q;
    j_d        = j_q;
    wbank_d    = wbank_q;
    serr_d     = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    frame_done = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (In_valid && In_sync) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          j_d      = AW'(1);
          wstate_d = W_FILL;
        end
      end
      W_FILL: begin
        if (In_valid) begin
          wr_en = 1'b1;
          if (In_sync && (j_q != '0)) begin
            // Early sync: the partial frame is dropped and this sample becomes index 0.
            serr_d  = 1'b1;
            wr_addr = '0;
            j_d     = AW'(1);
          end else begin
            wr_addr = bitrev(j_q);
            j_d     = j_q + AW'(1);
            if (j_q == AW'(N-1)) begin
              frame_done = 1'b1;
              wbank_d    = ~wbank_q;
              j_d        = '0;
            end
          end
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read side: walk the completed bank in natural order, chaining straight into a new frame.
  always_comb begin
    rstate_d = rstate_q;
    k_d      = k_q;
    rbank_d  = rbank_q;
    ovld_d   = 1'b0;
    osync_d  = 1'b0;
    or_d     = '0;
    oi_d     = '0;
    if (rstate_q == R_RUN) begin
      ovld_d       = 1'b1;
      osync_d      = (k_q == '0);
      {or_d, oi_d} = mem_q[{rbank_q, k_q}];
      k_d          = k_q + AW'(1);
      if (k_q == AW'(N-1)) rstate_d = R_IDLE;
    end
    // Completion only lands when the reader is idle or on its last bin.
    if (frame_done) begin
      rstate_d = R_RUN;
      k_d      = '0;
      rbank_d  = wbank_q;
    end
  end

  // Sample storage; contents survive reset on purpose.
  always_ff @(posedge CLK) begin
    if (wr_en && !RST) mem_q[{wbank_q, wr_addr}] <= {Data_in_r, Data_in_i};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wstate_q <= W_IDLE;
      j_q      <= '0;
      wbank_q  <= 1'b0;
      serr_q   <= 1'b0;
      rstate_q <= R_IDLE;
      k_q      <= '0;
      rbank_q  <= 1'b0;
      ovld_q   <= 1'b0;
      osync_q  <= 1'b0;
      or_q     <= '0;
      oi_q     <= '0;
    end else begin
      wstate_q <= wstate_d;
      j_q      <= j_d;
      wbank_q  <= wbank_d;
      serr_q   <= serr_d;
      rstate_q <= rstate_d;
      k_q      <= k_d;
      rbank_q  <= rbank_d;
      ovld_q   <= ovld_d;
      osync_q  <= osync_d;
      or_q     <= or_d;
      oi_q     <= oi_d;
    end
  end

  assign Out_valid  = ovld_q;
  assign Out_sync   = osync_q;
  assign Data_out_r = or_q;
  assign Data_out_i = oi_q;
  assign Sync_err   = serr_q;

endmodule

// File: tb/tb_fft_reorder_256.sv
// Bench for fft_reorder_256: directed frames with hand-derived natural-order expectations.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Covers reset, ordering, back-to-back, gaps, early sync and mid-frame reset.
module tb_fft_reorder_256;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        In_valid = 1'b0;
  logic        In_sync = 1'b0;
  logic [15:0] Data_in_r = '0;
  logic [15:0] Data_in_i = '0;
  logic        Out_valid, Out_sync, Sync_err;
  logic [15:0] Data_out_r, Data_out_i;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int serr_cnt = 0;
  int serr_cyc = -1;

  fft_reorder_256 #(.N(256), .W(16)) dut (
    .CLK(CLK), .RST(RST), .In_valid(In_valid), .In_sync(In_sync),
    .Data_in_r(Data_in_r), .Data_in_i(Data_in_i),
    .Out_valid(Out_valid), .Out_sync(Out_sync),
    .Data_out_r(Data_out_r), .Data_out_i(Data_out_i), .Sync_err(Sync_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (Sync_err === 1'b1) begin
      serr_cnt <= serr_cnt + 1;
      serr_cyc <= cyc;
    end
  end

  function automatic int br8(input int v);
    int r = 0;
    for (int b = 0; b < 8; b++) if (v[b]) r |= (1 << (7 - b));
    return r;
  endfunction

  // Input stimulus: mode 0 puts bitrev(j) in the real part, mode 1 a plain ramp.
  function automatic logic [15:0] in_r(input int mode, input int f, input int j);
    return (mode == 0) ? 16'(br8(j) + 256 * f) : 16'(j + 256 * f);
  endfunction
  function automatic logic [15:0] in_i(input int mode, input int f, input int j);
    return (mode == 0) ? ~in_r(mode, f, j) : (in_r(mode, f, j) ^ 16'h5a5a);
  endfunction
  // Expected natural-order output, written directly from the stimulus definition.
  function automatic logic [15:0] ex_r(input int mode, input int f, input int k);
    return (mode == 0) ? 16'(k + 256 * f) : 16'(br8(k) + 256 * f);
  endfunction
  function automatic logic [15:0] ex_i(input int mode, input int f, input int k);
    return (mode == 0) ? ~ex_r(mode, f, k) : (ex_r(mode, f, k) ^ 16'h5a5a);
  endfunction

  task automatic drive(input int mode, input int nframes, input bit gaps, input bit sync_all);
    for (int f = 0; f < nframes; f++) begin
      for (int j = 0; j < 256; j++) begin
        In_valid  = 1'b1;
        In_sync   = (j == 0) && (f == 0 || sync_all);
        Data_in_r = in_r(mode, f, j);
        Data_in_i = in_i(mode, f, j);
        @(negedge CLK);
        if (gaps) begin
          In_valid  = 1'b0;
          In_sync   = 1'b1;
          Data_in_r = 16'hbeef;
          Data_in_i = 16'hcafe;
          @(negedge CLK);
        end
      end
    end
    In_valid = 1'b0;
    In_sync  = 1'b0;
  endtask

  task automatic expect_frames(input string name, input int mode, input int nframes, input int exp_start);
    int waited = 0;
    while (Out_valid !== 1'b1 && waited < 2000) begin
      @(negedge CLK);
      waited++;
    end
    vecs++;
    if (Out_valid !== 1'b1) begin
      errs++;
      $display("FAIL %s timeout: Out_valid never rose, want start cycle %0d", name, exp_start);
      return;
    end
    if (cyc !== exp_start) begin
      errs++;
      $display("FAIL %s start: got cycle %0d, want %0d", name, cyc, exp_start);
    end
    for (int f = 0; f < nframes; f++) begin
      for (int k = 0; k < 256; k++) begin
        vecs++;
        if ({Out_valid, Out_sync, Data_out_r, Data_out_i} !==
            {1'b1, (k == 0), ex_r(mode, f, k), ex_i(mode, f, k)}) begin
          errs++;
          $display("FAIL %s f%0d k%0d: got v=%b s=%b r=%h i=%h, want v=1 s=%b r=%h i=%h",
                   name, f, k, Out_valid, Out_sync, Data_out_r, Data_out_i,
                   (k == 0), ex_r(mode, f, k), ex_i(mode, f, k));
        end
        @(negedge CLK);
      end
    end
    vecs++;
    if ({Out_valid, Out_sync, Data_out_r, Data_out_i} !== 34'd0) begin
      errs++;
      $display("FAIL %s tail: got v=%b s=%b r=%h i=%h, want all 0",
               name, Out_valid, Out_sync, Data_out_r, Data_out_i);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    In_valid = 1'b1;
    In_sync = 1'b1;
    repeat (3) @(negedge CLK);
    vecs++;
    if ({Out_valid, Out_sync, Data_out_r, Data_out_i, Sync_err} !== 35'd0) begin
      errs++;
      $display("FAIL reset: got v=%b s=%b r=%h i=%h e=%b, want all 0",
               Out_valid, Out_sync, Data_out_r, Data_out_i, Sync_err);
    end
    In_valid = 1'b0;
    In_sync = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic run_frames(input string name, input int mode, input int nframes, input bit gaps);
    int c0 = cyc;
    int base = serr_cnt;
    int start = gaps ? c0 + 512 : c0 + 257;
    fork
      drive(mode, nframes, gaps, 1'b0);
      expect_frames(name, mode, nframes, start);
    join
    vecs++;
    if (serr_cnt !== base) begin
      errs++;
      $display("FAIL %s sync_err: got %0d pulses, want 0", name, serr_cnt - base);
    end
  endtask

  task automatic test_natural();      run_frames("natural", 0, 1, 1'b0); endtask
  task automatic test_ramp();         run_frames("ramp", 1, 1, 1'b0); endtask
  task automatic test_back_to_back(); run_frames("back_to_back", 0, 3, 1'b0); endtask
  task automatic test_gaps();         run_frames("gaps", 0, 1, 1'b1); endtask

  task automatic test_sync_err();
    int c0 = cyc;
    int base = serr_cnt;
    fork
      begin
        for (int j = 0; j < 100; j++) begin
          In_valid  = 1'b1;
          In_sync   = (j == 0);
          Data_in_r = 16'hdead ^ 16'(j);
          Data_in_i = 16'(j);
          @(negedge CLK);
        end
        drive(0, 1, 1'b0, 1'b0);
      end
      expect_frames("sync_err", 0, 1, c0 + 357);
    join
    vecs++;
    if (serr_cnt - base !== 1) begin
      errs++;
      $display("FAIL sync_err count: got %0d pulses, want 1", serr_cnt - base);
    end
    vecs++;
    if (serr_cyc !== c0 + 101) begin
      errs++;
      $display("FAIL sync_err timing: got cycle %0d, want %0d", serr_cyc, c0 + 101);
    end
  endtask

  task automatic test_reset_mid();
    int c0 = cyc;
    int seen = 0;
    int guard = 0;
    drive(0, 1, 1'b0, 1'b0);
    while (cyc < c0 + 307 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    vecs++;
    if ({Out_valid, Data_out_r} !== {1'b1, 16'd50}) begin
      errs++;
      $display("FAIL reset_mid bin50: got v=%b r=%h, want v=1 r=0032", Out_valid, Data_out_r);
    end
    RST = 1'b1;
    @(negedge CLK);
    vecs++;
    if ({Out_valid, Out_sync, Data_out_r, Data_out_i} !== 34'd0) begin
      errs++;
      $display("FAIL reset_mid abort: got v=%b s=%b r=%h i=%h, want all 0",
               Out_valid, Out_sync, Data_out_r, Data_out_i);
    end
    RST = 1'b0;
    for (int j = 0; j < 600; j++) begin
      In_valid  = (j < 300);
      In_sync   = 1'b0;
      Data_in_r = 16'(j);
      Data_in_i = 16'(j);
      @(negedge CLK);
      if (Out_valid === 1'b1) seen++;
    end
    In_valid = 1'b0;
    vecs++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL reset_mid nosync: got %0d valid outputs, want 0", seen);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_natural();
    test_ramp();
    test_back_to_back();
    test_gaps();
    test_sync_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
